game_round_controller: RTL and testbench

//  Round sequencer for the fighting game: owns game_state, both players' health/block

---
 rtl/game_round_controller.sv | 178 +++++++++++++++++
 tb/tb_game_round_controller.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_controller.sv
// Round sequencer for the fighting game: owns game_state, both players' health and block bars,
// the round timer and the winner. It walks MENU -> COUNTDOWN -> GAME -> END -> MENU.
module game_round_controller #(
  parameter int TICKS_PER_SEC     = 60,
  parameter int ROUND_SECONDS     = 99,
  parameter int COUNTDOWN_SECONDS = 3,
  parameter int BLOCK_REGEN_SECS  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_pulse,
  input  logic       p1_hit,
  input  logic       p2_hit,
  input  logic       p1_blocked,
  input  logic       p2_blocked,
  output logic [2:0] game_state,
  output logic [2:0] char1_health,
  output logic [2:0] char1_block,
  output logic [2:0] char2_health,
  output logic [2:0] char2_block,
  output logic [6:0] timer_sec,
  output logic [1:0] winner,
  output logic       round_over
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SEC - 1);
  localparam logic [6:0]    ROUND_LOAD = 7'(ROUND_SECONDS);
  localparam logic [6:0]    CD_LOAD    = 7'(COUNTDOWN_SECONDS);
  localparam logic [3:0]    REGEN_LAST = 4'(BLOCK_REGEN_SECS - 1);

  typedef enum logic [1:0] {
    S_MENU      = 2'd0,
    S_GAME      = 2'd1,
    S_COUNTDOWN = 2'd2,
    S_END       = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    regen_cnt;

  // Encoding of state matches the published game_state values, so it doubles as the debug view.
  assign game_state = {1'b0, state};

  // One player's combat update: a hit wins over a same-cycle block; blocking on an
  // empty block bar costs health instead.
  function automatic logic [5:0] combat(input logic [2:0] h, input logic [2:0] b,
                                        input logic hit, input logic blk);
    logic [2:0] nh;
    logic [2:0] nb;
    nh = h;
    nb = b;
    if (hit) begin
      nh = h >> 1;
    end else if (blk) begin
      if (b != 3'b000) nb = b >> 1;
      else             nh = h >> 1;
    end
    return {nh, nb};
  endfunction

  logic          counting;
  logic          sec_done;
  logic [TW-1:0] tick_next;
  logic          regen_due;
  logic [2:0]    b1_base;
  logic [2:0]    b2_base;
  logic [5:0]    p1_next;
  logic [5:0]    p2_next;
  logic [2:0]    h1_n;
  logic [2:0]    b1_n;
  logic [2:0]    h2_n;
  logic [2:0]    b2_n;
  logic          ko;
  logic          timeout;
  logic [1:0]    ko_winner;
  logic [1:0]    time_winner;

  always_comb begin
    counting  = (state == S_COUNTDOWN) || (state == S_GAME);
    sec_done  = counting && frame_tick && (tick_cnt == TICK_LAST);
    tick_next = tick_cnt;
    if (frame_tick) begin
      tick_next = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
    end
    regen_due = (state == S_GAME) && sec_done && (regen_cnt == REGEN_LAST);
    // Regen is applied first so a same-cycle block consumes the refilled segment.
    b1_base   = regen_due ? {char1_block[1:0], 1'b1} : char1_block;
    b2_base   = regen_due ? {char2_block[1:0], 1'b1} : char2_block;
    p1_next   = combat(char1_health, b1_base, p1_hit, p1_blocked);
    p2_next   = combat(char2_health, b2_base, p2_hit, p2_blocked);
    h1_n      = p1_next[5:3];
    b1_n      = p1_next[2:0];
    h2_n      = p2_next[5:3];
    b2_n      = p2_next[2:0];
    ko        = (h1_n == 3'b000) || (h2_n == 3'b000);
    timeout   = sec_done && (timer_sec == 7'd1);
    ko_winner = 2'd1;
    if ((h1_n == 3'b000) && (h2_n == 3'b000)) ko_winner = 2'd3;
    else if (h1_n == 3'b000)                  ko_winner = 2'd2;
    // Thermometer codes order the same way as their set-bit counts.
    time_winner = 2'd3;
    if (h1_n > h2_n)      time_winner = 2'd1;
    else if (h2_n > h1_n) time_winner = 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_MENU;
      tick_cnt     <= '0;
      regen_cnt    <= '0;
      char1_health <= 3'b111;
      char1_block  <= 3'b111;
      char2_health <= 3'b111;
      char2_block  <= 3'b111;
      timer_sec    <= ROUND_LOAD;
      winner       <= 2'd0;
      round_over   <= 1'b0;
    end else begin
      round_over <= 1'b0;
      case (state)
        S_MENU: begin
          if (start_pulse) begin
            state        <= S_COUNTDOWN;
            char1_health <= 3'b111;
            char1_block  <= 3'b111;
            char2_health <= 3'b111;
            char2_block  <= 3'b111;
            timer_sec    <= CD_LOAD;
            tick_cnt     <= '0;
            winner       <= 2'd0;
          end
        end
        S_COUNTDOWN: begin
          tick_cnt <= tick_next;
          if (sec_done) begin
            if (timer_sec == 7'd1) begin
              state     <= S_GAME;
              timer_sec <= ROUND_LOAD;
              regen_cnt <= '0;
            end else begin
              timer_sec <= timer_sec - 7'd1;
            end
          end
        end
        S_GAME: begin
          tick_cnt     <= tick_next;
          char1_health <= h1_n;
          char1_block  <= b1_n;
          char2_health <= h2_n;
          char2_block  <= b2_n;
          if (sec_done) begin
            regen_cnt <= regen_due ? 4'd0 : regen_cnt + 4'd1;
          end
          if (ko) begin
            state      <= S_END;
            winner     <= ko_winner;
            round_over <= 1'b1;
          end else if (timeout) begin
            state      <= S_END;
            timer_sec  <= 7'd0;
            winner     <= time_winner;
            round_over <= 1'b1;
          end else if (sec_done) begin
            timer_sec <= timer_sec - 7'd1;
          end
        end
        S_END: begin
          if (start_pulse) state <= S_MENU;
        end
        default: state <= S_MENU;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Bench for game_round_controller: directed round scenarios with literal expectations, then
// random stimulus, all outputs compared every cycle against a level-based round model.
module tb_game_round_controller;

  localparam int TPS = 2;
  localparam int RS  = 5;
  localparam int CS  = 3;
  localparam int RG  = 2;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       start_pulse;
  logic       p1_hit;
  logic       p2_hit;
  logic       p1_blocked;
  logic       p2_blocked;
  logic [2:0] game_state;
  logic [2:0] char1_health;
  logic [2:0] char1_block;
  logic [2:0] char2_health;
  logic [2:0] char2_block;
  logic [6:0] timer_sec;
  logic [1:0] winner;
  logic       round_over;

  int n_tests;
  int n_fail;

  game_round_controller #(
    .TICKS_PER_SEC(TPS), .ROUND_SECONDS(RS), .COUNTDOWN_SECONDS(CS), .BLOCK_REGEN_SECS(RG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_pulse(start_pulse),
    .p1_hit(p1_hit), .p2_hit(p2_hit), .p1_blocked(p1_blocked), .p2_blocked(p2_blocked),
    .game_state(game_state), .char1_health(char1_health), .char1_block(char1_block),
    .char2_health(char2_health), .char2_block(char2_block), .timer_sec(timer_sec),
    .winner(winner), .round_over(round_over)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (bar levels 0..3, plain counters) ----------------
  int m_state;   // 0 menu, 1 game, 2 countdown, 3 end
  int m_h1, m_b1, m_h2, m_b2;
  int m_timer, m_frames, m_gsecs, m_winner, m_ro;

  function automatic int therm(input int lvl);
    return (1 << lvl) - 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_h1 = 3; m_b1 = 3; m_h2 = 3; m_b2 = 3;
    m_timer = RS; m_frames = 0; m_gsecs = 0; m_winner = 0; m_ro = 0;
  endtask

  task automatic take(inout int h, inout int b, input logic hit, input logic blk);
    if (hit) begin
      if (h > 0) h--;
    end else if (blk) begin
      if (b > 0) b--;
      else if (h > 0) h--;
    end
  endtask

  task automatic model_step();
    bit sec;
    m_ro = 0;
    sec  = 0;
    case (m_state)
      0: if (start_pulse) begin
        m_state = 2; m_h1 = 3; m_b1 = 3; m_h2 = 3; m_b2 = 3;
        m_timer = CS; m_frames = 0; m_winner = 0;
      end
      2: if (frame_tick) begin
        m_frames++;
        if (m_frames == TPS) begin
          m_frames = 0;
          if (m_timer == 1) begin
            m_state = 1; m_timer = RS; m_gsecs = 0;
          end else m_timer--;
        end
      end
      1: begin
        if (frame_tick) begin
          m_frames++;
          if (m_frames == TPS) begin
            m_frames = 0; sec = 1; m_gsecs++;
          end
        end
        if (sec && (m_gsecs % RG == 0)) begin
          if (m_b1 < 3) m_b1++;
          if (m_b2 < 3) m_b2++;
        end
        take(m_h1, m_b1, p1_hit, p1_blocked);
        take(m_h2, m_b2, p2_hit, p2_blocked);
        if (m_h1 == 0 || m_h2 == 0) begin
          m_state = 3; m_ro = 1;
          m_winner = (m_h1 == 0 && m_h2 == 0) ? 3 : (m_h1 == 0 ? 2 : 1);
        end else if (sec) begin
          if (m_timer == 1) begin
            m_timer = 0; m_state = 3; m_ro = 1;
            m_winner = (m_h1 > m_h2) ? 1 : ((m_h2 > m_h1) ? 2 : 3);
          end else m_timer--;
        end
      end
      default: if (start_pulse) m_state = 0;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    check("state",      int'(game_state),   m_state);
    check("p1_health",  int'(char1_health), therm(m_h1));
    check("p1_block",   int'(char1_block),  therm(m_b1));
    check("p2_health",  int'(char2_health), therm(m_h2));
    check("p2_block",   int'(char2_block),  therm(m_b2));
    check("timer",      int'(timer_sec),    m_timer);
    check("winner",     int'(winner),       m_winner);
    check("round_over", int'(round_over),   m_ro);
  end

  // ---------------- driver tasks ----------------
  // One-cycle pulse of the given inputs; returns just after the capturing edge.
  task automatic step(input logic s, input logic ft, input logic ph1, input logic ph2,
                      input logic pb1, input logic pb2);
    @(negedge clk);
    start_pulse = s; frame_tick = ft;
    p1_hit = ph1; p2_hit = ph2; p1_blocked = pb1; p2_blocked = pb2;
    @(posedge clk);
    #1;
    start_pulse = 0; frame_tick = 0;
    p1_hit = 0; p2_hit = 0; p1_blocked = 0; p2_blocked = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic enter_game();
    if (m_state == 1 || m_state == 2) do_reset();
    if (m_state == 3) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (6) step(0, 1, 0, 0, 0, 0);
    check("lit_enter_game", int'(game_state), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 0; frame_tick = 0; start_pulse = 0;
    p1_hit = 0; p2_hit = 0; p1_blocked = 0; p2_blocked = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    check("lit_rst_state", int'(game_state), 0);
    check("lit_rst_health", int'(char1_health), 7);
    check("lit_rst_block", int'(char2_block), 7);
    check("lit_rst_timer", int'(timer_sec), 5);
    check("lit_rst_winner", int'(winner), 0);

    // countdown, combat ignored, entry into GAME
    step(1, 0, 0, 0, 0, 0);
    check("lit_cd_state", int'(game_state), 2);
    check("lit_cd_timer", int'(timer_sec), 3);
    step(0, 0, 1, 0, 0, 0);
    check("lit_cd_hit_ignored", int'(char1_health), 7);
    repeat (5) step(0, 1, 0, 0, 0, 0);
    check("lit_cd_last_sec", int'(timer_sec), 1);
    step(0, 1, 0, 0, 0, 0);
    check("lit_game_state", int'(game_state), 1);
    check("lit_game_timer", int'(timer_sec), 5);

    // KO of player 2
    step(0, 0, 0, 1, 0, 0);
    check("lit_p2_h1", int'(char2_health), 3);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("lit_p2_h2", int'(char2_health), 1);
    step(0, 0, 0, 1, 0, 0);
    check("lit_p2_h3", int'(char2_health), 0);
    check("lit_ko_state", int'(game_state), 3);
    check("lit_ko_winner", int'(winner), 1);
    check("lit_ko_pulse", int'(round_over), 1);
    step(0, 0, 0, 0, 0, 0);
    check("lit_ko_pulse_end", int'(round_over), 0);

    // blocking drains the bar, then costs health; hit beats block
    enter_game();
    step(0, 0, 0, 0, 1, 0);
    check("lit_blk1", int'(char1_block), 3);
    step(0, 0, 0, 0, 1, 0);
    check("lit_blk2", int'(char1_block), 1);
    step(0, 0, 0, 0, 1, 0);
    check("lit_blk3", int'(char1_block), 0);
    step(0, 0, 0, 0, 1, 0);
    check("lit_blk4_health", int'(char1_health), 3);
    step(0, 0, 1, 0, 1, 0);
    check("lit_hit_blk_health", int'(char1_health), 1);
    check("lit_hit_blk_block", int'(char1_block), 0);

    // block regen, then regen with a same-cycle block, then a drawn timeout
    enter_game();
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check("lit_regen_pre", int'(char1_block), 1);
    repeat (4) step(0, 1, 0, 0, 0, 0);
    check("lit_regen", int'(char1_block), 3);
    check("lit_regen_timer", int'(timer_sec), 3);
    step(0, 0, 0, 0, 1, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    check("lit_regen_consume", int'(char1_block), 1);
    check("lit_regen_timer2", int'(timer_sec), 1);
    repeat (2) step(0, 1, 0, 0, 0, 0);
    check("lit_draw_timer", int'(timer_sec), 0);
    check("lit_draw_state", int'(game_state), 3);
    check("lit_draw_winner", int'(winner), 3);

    // timeout with player 2 ahead
    enter_game();
    step(0, 0, 1, 0, 0, 0);
    repeat (9) step(0, 1, 0, 0, 0, 0);
    check("lit_to_pre_timer", int'(timer_sec), 1);
    step(0, 1, 0, 0, 0, 0);
    check("lit_to_timer", int'(timer_sec), 0);
    check("lit_to_state", int'(game_state), 3);
    check("lit_to_winner", int'(winner), 2);

    // double KO, back to menu with frozen bars, reset mid-round
    enter_game();
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    check("lit_dko_winner", int'(winner), 3);
    check("lit_dko_state", int'(game_state), 3);
    step(1, 0, 0, 0, 0, 0);
    check("lit_menu_state", int'(game_state), 0);
    check("lit_menu_frozen", int'(char1_health), 0);
    enter_game();
    step(0, 0, 1, 0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    check("lit_async_state", int'(game_state), 0);
    check("lit_async_health", int'(char1_health), 7);
    @(negedge clk);
    rst_n = 1;

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end
    end

    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
